// File: rtl/host_key_decoder.sv
// PS/2 set-2 scan-code decoder: turns make/break/extended byte sequences into
// held-key levels {reset, jump, right, left} for the movement controller.
module host_key_decoder #(
    parameter logic [7:0]  KEY_LEFT    = 8'h6B,
    parameter logic [7:0]  KEY_RIGHT   = 8'h74,
    parameter logic [7:0]  KEY_JUMP    = 8'h75,
    parameter logic [7:0]  KEY_RESET   = 8'h2D,
    parameter logic [3:0]  EXT_MASK    = 4'b0111,
    parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       left,
    output logic       right,
    output logic       jump,
    output logic       reset
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;
    localparam logic [7:0] CODE_NUL = 8'h00;
    localparam logic [7:0] CODE_OVR = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       keys_q, keys_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       make_en;
    logic       brk_en;
    logic       ext_sel;
    logic [3:0] hit;

    // Next-state, key-level and prefix-timeout logic.
    always_comb begin
        state_d = state_q;
        keys_d  = keys_q;
        cnt_d   = cnt_q;
        make_en = 1'b0;
        brk_en  = 1'b0;
        ext_sel = 1'b0;
        hit     = 4'b0000;

        if (clear) begin
            state_d = S_IDLE;
            keys_d  = 4'b0000;
            cnt_d   = '0;
        end else if (rx_valid) begin
            cnt_d = '0;
            if (rx_data == CODE_NUL || rx_data == CODE_OVR) begin
                state_d = S_IDLE;
                keys_d  = 4'b0000;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (rx_data == CODE_EXT)      state_d = S_EXT;
                        else if (rx_data == CODE_BRK) state_d = S_BRK;
                        else                          make_en = 1'b1;
                    end
                    S_EXT: begin
                        if (rx_data == CODE_BRK)      state_d = S_EXT_BRK;
                        else if (rx_data == CODE_EXT) state_d = S_EXT;
                        else begin
                            make_en = 1'b1;
                            ext_sel = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                    S_BRK: begin
                        state_d = S_IDLE;
                        if (rx_data != CODE_EXT && rx_data != CODE_BRK) brk_en = 1'b1;
                    end
                    S_EXT_BRK: begin
                        state_d = S_IDLE;
                        ext_sel = 1'b1;
                        if (rx_data != CODE_EXT && rx_data != CODE_BRK) brk_en = 1'b1;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end else if (state_q != S_IDLE) begin
            // A prefix with no follow-up byte is abandoned; held keys are kept.
            if (cnt_q == CNT_LAST) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        hit[0] = (rx_data == KEY_LEFT)  && (ext_sel == EXT_MASK[0]);
        hit[1] = (rx_data == KEY_RIGHT) && (ext_sel == EXT_MASK[1]);
        hit[2] = (rx_data == KEY_JUMP)  && (ext_sel == EXT_MASK[2]);
        hit[3] = (rx_data == KEY_RESET) && (ext_sel == EXT_MASK[3]);

        for (int i = 0; i < 4; i++) begin
            if (hit[i] && make_en) keys_d[i] = 1'b1;
            if (hit[i] && brk_en)  keys_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            keys_q  <= 4'b0000;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            keys_q  <= keys_d;
            cnt_q   <= cnt_d;
        end
    end

    assign left  = keys_q[0];
    assign right = keys_q[1];
    assign jump  = keys_q[2];
    assign reset = keys_q[3];

endmodule

// File: tb/tb_host_key_decoder.sv
// Directed bench for host_key_decoder: vector table plus hand-written
// sequences for prefix timeout, typematic repeat and mid-sequence reset.
module tb_host_key_decoder;

    localparam int unsigned TO_CYC = 2000;

    logic       clk;
    logic       rst;
    logic       clear;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       left, right, jump, reset;

    int checks;
    int errors;

    host_key_decoder #(.TIMEOUT_CYC(TO_CYC)) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .left     (left),
        .right    (right),
        .jump     (jump),
        .reset    (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       clr;
        logic       vld;
        logic [7:0] data;
        logic [3:0] exp;   // {reset, jump, right, left}
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic clr, input logic vld, input logic [7:0] data,
                       input logic [3:0] exp);
        vec_t v;
        v.clr = clr; v.vld = vld; v.data = data; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] exp);
        logic [3:0] got;
        got = {reset, jump, right, left};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got keys=%b expected %b", name, got, exp);
        end
    endtask

    // One input cycle; outputs are sampled 1 ns after the capturing edge.
    task automatic drive(input logic clr, input logic vld, input logic [7:0] data);
        @(negedge clk);
        clear    = clr;
        rx_valid = vld;
        rx_data  = data;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        clear    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // Table: main decode paths from a fresh reset.
        add(0, 1, 8'hE0, 4'b0000);
        add(0, 1, 8'h74, 4'b0010);  // right make
        add(0, 1, 8'hE0, 4'b0010);
        add(0, 1, 8'h75, 4'b0110);  // jump make, right still held
        add(0, 1, 8'hE0, 4'b0110);
        add(0, 1, 8'hF0, 4'b0110);
        add(0, 1, 8'h74, 4'b0100);  // right break, jump stays
        add(0, 1, 8'h2D, 4'b1100);  // reset key, non-extended
        add(0, 1, 8'h6B, 4'b1100);  // left without E0 ignored
        add(0, 1, 8'hF0, 4'b1100);
        add(0, 1, 8'h2D, 4'b0100);  // reset break
        add(0, 1, 8'hE0, 4'b0100);
        add(0, 1, 8'h12, 4'b0100);  // fake shift
        add(0, 1, 8'hE0, 4'b0100);
        add(0, 1, 8'h6B, 4'b0101);  // left make
        add(0, 1, 8'hFA, 4'b0101);
        add(0, 1, 8'hE1, 4'b0101);
        add(0, 1, 8'hFF, 4'b0000);  // overrun clears all
        add(0, 1, 8'hE0, 4'b0000);
        add(0, 1, 8'h6B, 4'b0001);
        add(0, 1, 8'hE0, 4'b0001);
        add(1, 1, 8'h2D, 4'b0000);  // clear wins over rx_valid
        add(0, 1, 8'h6B, 4'b0000);  // decoded from IDLE after clear
        add(0, 1, 8'h2D, 4'b1000);
        add(0, 1, 8'hF0, 4'b1000);
        add(0, 1, 8'hE0, 4'b1000);  // malformed F0 E0 discarded
        add(0, 1, 8'h6B, 4'b1000);  // so 6B is non-extended here
        add(0, 1, 8'h00, 4'b0000);  // 00 overrun
        add(0, 1, 8'hE0, 4'b0000);
        add(0, 1, 8'hE0, 4'b0000);  // repeated E0 keeps EXT
        add(0, 1, 8'h6B, 4'b0001);
        add(0, 1, 8'hE0, 4'b0001);
        add(0, 1, 8'hF0, 4'b0001);
        add(0, 1, 8'h6B, 4'b0000);
        add(0, 0, 8'h6B, 4'b0000);  // data without valid ignored

        #12;
        check("reset_state", 4'b0000);
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        check("after_reset_release", 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].clr, vecs[i].vld, vecs[i].data);
            checks++;
            if ({reset, jump, right, left} !== vecs[i].exp) begin
                errors++;
                $display("FAIL vec%0d data=%h: got keys=%b expected %b",
                         i, vecs[i].data, {reset, jump, right, left}, vecs[i].exp);
            end
        end

        // E0 then a 1000-cycle gap, still inside the timeout.
        drive(0, 1, 8'hE0);
        idle(1000);
        check("gap_before_6b", 4'b0000);
        drive(0, 1, 8'h6B);
        check("gap_left_make", 4'b0001);
        drive(0, 1, 8'hE0);
        drive(0, 1, 8'hF0);
        drive(0, 1, 8'h6B);
        check("gap_left_break", 4'b0000);

        // Last cycle before timeout still accepts the follow-up byte.
        drive(0, 1, 8'hE0);
        idle(TO_CYC - 1);
        drive(0, 1, 8'h6B);
        check("timeout_edge_accept", 4'b0001);

        // Timeout with a key held: output unchanged, prefix dropped.
        drive(0, 1, 8'hE0);
        idle(TO_CYC);
        check("timeout_hold", 4'b0001);
        drive(0, 1, 8'hF0);
        drive(0, 1, 8'h6B);
        check("timeout_prefix_dropped", 4'b0001);  // F0 6B is a non-ext break
        drive(0, 1, 8'hE0);
        drive(0, 1, 8'hF0);
        drive(0, 1, 8'h6B);
        check("left_release", 4'b0000);

        // Timeout then 6B alone must not make left.
        drive(0, 1, 8'hE0);
        idle(TO_CYC + 2);
        drive(0, 1, 8'h6B);
        check("timeout_ignore_6b", 4'b0000);

        // Typematic repeat keeps left high.
        for (int k = 0; k < 10; k++) begin
            drive(0, 1, 8'hE0);
            drive(0, 1, 8'h6B);
            check($sformatf("typematic_%0d", k), 4'b0001);
        end
        drive(0, 1, 8'hE0);
        drive(0, 1, 8'h75);
        check("jump_with_left", 4'b0101);

        // Async reset in the middle of E0 F0.
        drive(0, 1, 8'hE0);
        drive(0, 1, 8'hF0);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_now", 4'b0000);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1, 8'h75);
        check("after_reset_75_idle", 4'b0000);

        // Async reset after E0: next byte decoded as non-extended.
        drive(0, 1, 8'hE0);
        #2;
        rst = 1'b0;
        #3;
        rst = 1'b1;
        drive(0, 1, 8'h74);
        check("after_reset_74_idle", 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
